// File: rtl/mpsoc_rst_seq.sv
// Reset and boot-strap sequencer: synchronises and debounces board inputs, then sequences CPU/NoC reset release.
// Optional macro RST_SEQ_PLL_LOCK_EN: when defined, the FSM waits for PLL lock and falls back to WAIT_LOCK on lock loss.
module mpsoc_rst_seq #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int RST_HOLD_CYCLES = 1024
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic pll_locked_i,
  input  logic rst_btn_i,
  input  logic uart_switch_i,
  input  logic bootloader_i,
  output logic rst_o,
  output logic uart_switch_o,
  output logic bootloader_o,
  output logic ready_o
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(RST_HOLD_CYCLES + 1);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(RST_HOLD_CYCLES - 1);
  localparam int BTN  = 0;
  localparam int UART = 1;
  localparam int BOOT = 2;

  typedef enum logic [1:0] {
    WAIT_LOCK,
    HOLD,
    RUN
  } state_t;

  logic [2:0]    raw;
  logic [2:0]    sync1_q, sync1_d;
  logic [2:0]    sync2_q, sync2_d;
  logic [2:0]    db_q, db_d;
  logic [DW-1:0] db_cnt_q [3];
  logic [DW-1:0] db_cnt_d [3];
  logic          lock;

  state_t        state_q, state_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic          boot_q, boot_d;
  logic          rst_q, rst_d;
  logic          ready_q, ready_d;

  assign raw = {bootloader_i, uart_switch_i, rst_btn_i};

  // Debounced value only moves after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_comb begin
    sync1_d = raw;
    sync2_d = sync1_q;
    db_d    = db_q;
    for (int i = 0; i < 3; i++) begin
      db_cnt_d[i] = '0;
      if (sync2_q[i] != db_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          db_d[i] = sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      sync1_q <= '0;
      sync2_q <= '0;
      db_q    <= '0;
      for (int i = 0; i < 3; i++) begin
        db_cnt_q[i] <= '0;
      end
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      db_q    <= db_d;
      for (int i = 0; i < 3; i++) begin
        db_cnt_q[i] <= db_cnt_d[i];
      end
    end
  end

`ifdef RST_SEQ_PLL_LOCK_EN
  logic lock_s1_q, lock_s1_d;
  logic lock_s2_q, lock_s2_d;

  always_comb begin
    lock_s1_d = pll_locked_i;
    lock_s2_d = lock_s1_q;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      lock_s1_q <= 1'b0;
      lock_s2_q <= 1'b0;
    end else begin
      lock_s1_q <= lock_s1_d;
      lock_s2_q <= lock_s2_d;
    end
  end

  assign lock = lock_s2_q;
`else
  // Simulation builds without a PLL: lock is permanently asserted.
  logic unused_pll_locked;
  assign unused_pll_locked = pll_locked_i;
  assign lock = 1'b1;
`endif

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    boot_d     = boot_q;
    case (state_q)
      WAIT_LOCK: begin
        if (lock) begin
          state_d    = HOLD;
          hold_cnt_d = '0;
        end
      end
      HOLD: begin
        // A pressed button wins over the final count, so no capture happens.
        if (db_q[BTN]) begin
          hold_cnt_d = '0;
        end else if (hold_cnt_q == HOLD_LAST) begin
          state_d    = RUN;
          hold_cnt_d = '0;
          boot_d     = db_q[BOOT];
        end else begin
          hold_cnt_d = hold_cnt_q + HW'(1);
        end
      end
      RUN: begin
        if (!lock) begin
          state_d = WAIT_LOCK;
        end else if (db_q[BTN]) begin
          state_d    = HOLD;
          hold_cnt_d = '0;
        end
      end
      default: begin
        state_d    = WAIT_LOCK;
        hold_cnt_d = '0;
      end
    endcase
    rst_d   = (state_d != RUN);
    ready_d = (state_d == RUN);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= WAIT_LOCK;
      hold_cnt_q <= '0;
      boot_q     <= 1'b0;
      rst_q      <= 1'b1;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      boot_q     <= boot_d;
      rst_q      <= rst_d;
      ready_q    <= ready_d;
    end
  end

  assign rst_o         = rst_q;
  assign ready_o       = ready_q;
  assign uart_switch_o = db_q[UART];
  assign bootloader_o  = boot_q;

endmodule

// File: doc/mpsoc_rst_seq.md
# mpsoc_rst_seq

Reset and boot-strap sequencer sitting directly upstream of the MPSoC top: it turns the raw board inputs (reset button, UART-select switch, bootloader switch, PLL lock) into clean, synchronised, debounced control signals. It drives the CPU/NoC reset and the `uart_switch`/`bootloader` straps consumed by the tile array and the UART mux. Reset release is sequenced so that all tiles and the NoC leave reset on the same edge, with the boot strap frozen for the whole run.

## Interface
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable cycles needed to accept a switch/button change (10 ms at 50 MHz); legal range ≥1.
- `RST_HOLD_CYCLES`, default 1024: cycles `rst_o` stays high after the release condition is met; legal range ≥1.
- `clk_in`  in  1  system clock (PLL output domain).
- `rst_in`  in  1  synchronous, active-high reset.
- `pll_locked_i`  in  1  PLL LOCKED, asynchronous.
- `rst_btn_i`  in  1  raw reset button, active high, asynchronous, bouncing.
- `uart_switch_i`  in  1  raw UART select switch (0 slave tile, 1 master tile), asynchronous.
- `bootloader_i`  in  1  raw bootloader switch, active high, asynchronous.
- `rst_o`  out  1  CPU/NoC reset, active high.
- `uart_switch_o`  out  1  debounced UART select, live.
- `bootloader_o`  out  1  boot strap, latched at reset release.
- `ready_o`  out  1  high while in RUN.

## Operation
- **Input conditioning:**
  - `pll_locked_i`, `rst_btn_i`, `uart_switch_i` and `bootloader_i` each pass through a 2-flop synchroniser.
  - `rst_btn`, `uart_switch` and `bootloader` then pass through a debouncer.
  - Each debouncer has its own counter of width $clog2(DEBOUNCE_CYCLES+1).
  - The counter increments while the synced value differs from the debounced value and clears to 0 when they are equal.
  - When the counter equals DEBOUNCE_CYCLES-1 and the values still differ, the debounced value flips on the next edge and the counter clears.
  - Lock is synchronised only, not debounced.
- **FSM states:** WAIT_LOCK, HOLD, RUN.
  - WAIT_LOCK: `rst_o`=1. Moves to HOLD when synced lock is 1; the hold counter clears.
  - HOLD: `rst_o`=1.
    - While debounced `rst_btn`=1, the hold counter is held at 0.
    - Otherwise it increments.
    - At count RST_HOLD_CYCLES-1 the FSM moves to RUN, and `bootloader_o` captures debounced `bootloader` on the same edge.
  - RUN: `rst_o`=0, `ready_o`=1.
    - Lock lost → WAIT_LOCK.
    - Else debounced `rst_btn`=1 → HOLD with the counter cleared.
    - Lock loss takes priority over the button.
- **UART select:** `uart_switch_o` equals debounced `uart_switch` in every state. It is not gated by reset, because the UART mux is combinational.
- **Boot strap:** `bootloader_o` holds its value in all states except the HOLD→RUN edge. Switch changes during RUN therefore take effect only on the next reset release.
- **Reset (`rst_in`=1):**
  - FSM goes to WAIT_LOCK; all synchronisers, debounced values and counters go to 0.
  - `rst_o`=1, `uart_switch_o`=0, `bootloader_o`=0, `ready_o`=0.
  - Reset asserted mid-HOLD or in RUN aborts immediately, with no partial count retained.

## Timing
- All outputs are registered.
- **Synchroniser latency:** 2 cycles.
- **Debounce latency:** a raw change held stable reaches the debounced value DEBOUNCE_CYCLES+2 cycles after the first sampling edge.
- **Glitches:** a glitch shorter than DEBOUNCE_CYCLES synced cycles produces no output change.
- **Reset release timing:**
  - `rst_o` falls exactly RST_HOLD_CYCLES cycles after HOLD entry with the button released.
  - From lock rising, this is 2 (sync) + 1 (WAIT_LOCK→HOLD) + RST_HOLD_CYCLES cycles.
- **Button press in RUN:** `rst_o` rises 1 cycle after debounced `rst_btn` rises.
- **Lock loss in RUN:** `rst_o` rises 1 cycle after synced lock falls.
- **Simultaneous events:**
  - Lock loss and button in the same cycle → WAIT_LOCK.
  - Button press on the final HOLD count cycle → stays in HOLD with the counter cleared, and no bootloader capture.
- **Stability:** `rst_o` never pulses low for less than one full RUN stay; there are no combinational paths from inputs to outputs.

## Configuration
- **`RST_SEQ_PLL_LOCK_EN` defined:** behaviour as above. The FSM waits for the PLL lock and returns to WAIT_LOCK on lock loss.
- **`RST_SEQ_PLL_LOCK_EN` undefined:**
  - `pll_locked_i` is ignored and its synchroniser is not built; lock is treated as constant 1.
  - WAIT_LOCK exits to HOLD on the first cycle after reset.
  - RUN never returns to WAIT_LOCK.
  - This setting is used for simulation builds without a PLL.

## Test plan
Benches run with DEBOUNCE_CYCLES=4 and RST_HOLD_CYCLES=8.
- **Power-up:** `rst_in` high 3 cycles; `pll_locked_i`=1 at cycle 5. → Outputs 1/0/0/0 during reset; `rst_o` falls 11 cycles after lock is sampled; `ready_o` rises on the same edge.
- **Bounce filtering:** in RUN, `rst_btn_i` toggles 1,0,1,0 on alternate cycles. → No `rst_o` change. Then hold it at 1 for 6 cycles. → `rst_o` rises 7 cycles after the first steady sample.
- **Strap freezing:** `bootloader_i`=1 during HOLD. → `bootloader_o`=1 at RUN entry. Set `bootloader_i`=0 in RUN. → `bootloader_o` stays 1 until the next HOLD→RUN edge.
- **Live UART select:** `uart_switch_i` 0→1 in RUN. → `uart_switch_o`=1 after 6 cycles; `rst_o` unaffected.
- **Lock loss with button:** drop `pll_locked_i` and press the button in the same cycle. → FSM in WAIT_LOCK, `rst_o`=1. Relock with the button released. → `rst_o` falls 11 cycles later.
- **Mid-HOLD reset and macro check:** assert `rst_in` at hold count 5. → Counter restarts from 0 after release. With `RST_SEQ_PLL_LOCK_EN` undefined and `pll_locked_i`=0: `rst_o` falls 9 cycles after `rst_in` deasserts.
